frame_sink: RTL and testbench
=============================

// Module: frame_sink
// PURPOSE
//  Drain side of the filter pipeline: pops filtered pixels from the filter's output FIFO (first-word-fall-through),
//  tracks raster x/y, optionally zeroes a BORDER-wide frame edge, and writes each pixel to a frame-buffer RAM port.
//  One frame per start pulse; reports frame_done, a per-frame pixel checksum and a frame counter for bench comparison.
// PARAMETERS
//  DWIDTH      8    pixel width (matches filter DWIDTH_OUT)
//  IMG_WIDTH   720  pixels per line
//  IMG_HEIGHT  540  lines per frame
//  BORDER      1    edge width forced to 0 (WINDOW_SIZE/2 of upstream filter); 0 = pass all
//  BASE_ADDR   0    RAM address of pixel (0,0)
//  AWIDTH      20   RAM address width; must hold BASE_ADDR+W*H-1
// PORTS
//  clock        in   1       clock
//  reset        in   1       synchronous, active-high
//  start        in   1       1-cycle pulse; arms collection of one frame
//  fifo_rd_en   out  1       pop; combinational
//  fifo_dout    in   DWIDTH  head-of-FIFO pixel, valid while !fifo_empty
//  fifo_empty   in   1       FIFO empty
//  mem_wr_en    out  1       registered RAM write strobe
//  mem_addr     out  AWIDTH  registered RAM address
//  mem_din      out  DWIDTH  registered RAM data
//  mem_busy     in   1       RAM stall: current write not accepted, hold outputs
//  busy         out  1       high in RUN/FLUSH
//  frame_done   out  1       1-cycle pulse after last write accepted
//  checksum     out  32      sum of written pixels mod 2^32, valid from frame_done until next start
//  frame_count  out  16      frames completed since reset, wraps
// BEHAVIOUR
//  Reset: state=IDLE; x=y=0; all outputs 0; FIFO contents untouched. Reset mid-frame aborts, no frame_done.
//  States: IDLE -start-> RUN (x,y,checksum cleared) -last pop-> FLUSH -last write accepted-> IDLE (frame_done=1).
//  start ignored outside IDLE; start with reset: reset wins.
//  fifo_rd_en = (state==RUN) && !fifo_empty && !(mem_wr_en && mem_busy). Never popped in IDLE/FLUSH.
//  Pop at (x,y): next cycle mem_wr_en=1, mem_addr=BASE_ADDR+y*IMG_WIDTH+x, mem_din=edge?0:fifo_dout;
//   edge = x<BORDER || x>=IMG_WIDTH-BORDER || y<BORDER || y>=IMG_HEIGHT-BORDER. Latency pop->write = 1 cycle.
//  No pop and write accepted: mem_wr_en drops to 0 next cycle. mem_busy with mem_wr_en=1: wr_en/addr/din held.
//  mem_busy with mem_wr_en=0: no effect on outputs (still blocks nothing); throughput 1 px/clk when unstalled.
//  x increments per pop; at x==IMG_WIDTH-1: x=0, y++. Pop at (W-1,H-1) -> FLUSH; x,y return to 0.
//  checksum += mem_din (zeroed value) on each accepted write (wr_en && !busy). frame_count++ with frame_done.
//  Address via running counter (add, no multiply); addr increments on pop; no wrap within a frame.
// STRUCTURE
//  Shared package: state encoding (IDLE/RUN/FLUSH), clog2 function, image-size defaults shared with filter.
//  Single flat module; raster x/y/edge logic is small enough to stay inline, no sub-module.
// TESTING  (W=4,H=3,BORDER=1,BASE_ADDR=0x10,DWIDTH=8 unless noted)
//  1 start; FIFO holds 1..12, never empty, mem_busy=0 -> 12 writes on consecutive cycles, addr 0x10..0x1B,
//    data 0 except addr 0x15=6,0x16=7; frame_done one cycle after last write; checksum=13; frame_count=1.
//  2 BORDER=0, same data -> data equals input, checksum=78; second start+frame -> checksum=78, frame_count=2.
//  3 fifo_empty toggled every other cycle -> rd_en only when !empty; writes gapped, same addr/data as test 2.
//  4 mem_busy held 3 cycles on the 5th write -> addr/din/wr_en frozen, rd_en=0, no pop lost or duplicated.
//  5 reset after 6 pops -> outputs 0, IDLE, no frame_done; new start + 12 fresh pixels -> full clean frame.
//  6 start pulsed during RUN and pixels present in IDLE -> ignored; no pop before start.

Source files
------------

// File: rtl/frame_sink_pkg.sv
// Shared definitions for the filter drain side: sink state encoding, image-size
// defaults common with the upstream filter, and a constant-width helper.
package frame_sink_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int DWIDTH_DEF      = 8;
  localparam int IMG_WIDTH_DEF   = 720;
  localparam int IMG_HEIGHT_DEF  = 540;
  localparam int WINDOW_SIZE_DEF = 3;

  // Bits needed to hold values 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/frame_sink_if.sv
// FIFO pop side and frame-buffer write port of the sink, bundled as one interface.
// master = the sink (pops, writes); slave = FIFO/RAM environment.
interface frame_sink_if
  import frame_sink_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = 20
) ();

  logic              fifo_rd_en;
  logic [DWIDTH-1:0] fifo_dout;
  logic              fifo_empty;
  logic              mem_wr_en;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_din;
  logic              mem_busy;

  modport master (
    output fifo_rd_en,
    input  fifo_dout,
    input  fifo_empty,
    output mem_wr_en,
    output mem_addr,
    output mem_din,
    input  mem_busy
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_dout,
    output fifo_empty,
    input  mem_wr_en,
    input  mem_addr,
    input  mem_din,
    output mem_busy
  );

endinterface

// File: rtl/frame_sink.sv
// Pops one frame of filtered pixels from a FWFT FIFO, zeroes the border, and
// writes them in raster order to the frame buffer; reports checksum and count.
module frame_sink
  import frame_sink_pkg::*;
#(
  parameter int DWIDTH     = DWIDTH_DEF,
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int BORDER     = WINDOW_SIZE_DEF / 2,
  parameter int BASE_ADDR  = 0,
  parameter int AWIDTH     = 20
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  frame_sink_if.master bus,
  output logic         busy,
  output logic         frame_done,
  output logic [31:0]  checksum,
  output logic [15:0]  frame_count
);

  localparam int XW = clog2(IMG_WIDTH);
  localparam int YW = clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  state_t            state;
  state_t            state_next;
  logic [XW-1:0]     x_pos;
  logic [YW-1:0]     y_pos;
  logic [AWIDTH-1:0] addr_run;
  logic              pop;
  logic              accept;
  logic              last_px;
  logic              on_edge;

  // A held (stalled) write blocks the pop so no pixel is lost while the RAM is busy.
  assign accept         = bus.mem_wr_en && !bus.mem_busy;
  assign pop            = (state == RUN) && !bus.fifo_empty && !(bus.mem_wr_en && bus.mem_busy);
  assign bus.fifo_rd_en = pop;
  assign last_px        = (x_pos == X_LAST) && (y_pos == Y_LAST);
  assign busy           = (state != IDLE);

  generate
    if (BORDER == 0) begin : g_no_border
      assign on_edge = 1'b0;
    end else begin : g_border
      localparam logic [XW-1:0] X_LO = XW'(BORDER);
      localparam logic [XW-1:0] X_HI = XW'(IMG_WIDTH - BORDER);
      localparam logic [YW-1:0] Y_LO = YW'(BORDER);
      localparam logic [YW-1:0] Y_HI = YW'(IMG_HEIGHT - BORDER);
      assign on_edge = (x_pos < X_LO) || (x_pos >= X_HI) ||
                       (y_pos < Y_LO) || (y_pos >= Y_HI);
    end
  endgenerate

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (pop && last_px) state_next = FLUSH;
      FLUSH:   if (accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stage p0: raster position, running address and frame bookkeeping
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      x_pos       <= '0;
      y_pos       <= '0;
      addr_run    <= '0;
      checksum    <= '0;
      frame_count <= '0;
      frame_done  <= 1'b0;
    end else begin
      state      <= state_next;
      frame_done <= (state == FLUSH) && accept;
      if (accept) checksum <= checksum + 32'(bus.mem_din);
      if ((state == FLUSH) && accept) frame_count <= frame_count + 16'd1;
      if ((state == IDLE) && start) begin
        x_pos    <= '0;
        y_pos    <= '0;
        addr_run <= AWIDTH'(BASE_ADDR);
        checksum <= '0;
      end else if (pop) begin
        addr_run <= addr_run + AWIDTH'(1);
        if (x_pos == X_LAST) begin
          x_pos <= '0;
          y_pos <= last_px ? '0 : y_pos + YW'(1);
        end else begin
          x_pos <= x_pos + XW'(1);
        end
      end
    end
  end

  // Stage p1: registered RAM write, held while the RAM stalls
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.mem_wr_en <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_din   <= '0;
    end else if (pop) begin
      bus.mem_wr_en <= 1'b1;
      bus.mem_addr  <= addr_run;
      bus.mem_din   <= on_edge ? '0 : bus.fifo_dout;
    end else if (accept) begin
      bus.mem_wr_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_sink.sv
// Random and directed frames driven into a BORDER=1 and a BORDER=0 sink in
// lockstep, checked against a pixel-index reference model.
module tb_frame_sink;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int NPX  = W * H;
  localparam int BASE = 16;
  localparam int DW   = 8;
  localparam int AW   = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_empty = 1'b1;
  logic          mem_busy = 1'b0;

  logic          busy1, done1, busy0, done0;
  logic [31:0]   sum1, sum0;
  logic [15:0]   cnt1, cnt0;

  frame_sink_if #(.DWIDTH(DW), .AWIDTH(AW)) bus1 ();
  frame_sink_if #(.DWIDTH(DW), .AWIDTH(AW)) bus0 ();

  assign bus1.fifo_dout  = fifo_dout;
  assign bus1.fifo_empty = fifo_empty;
  assign bus1.mem_busy   = mem_busy;
  assign bus0.fifo_dout  = fifo_dout;
  assign bus0.fifo_empty = fifo_empty;
  assign bus0.mem_busy   = mem_busy;

  frame_sink #(.DWIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .BORDER(1),
               .BASE_ADDR(BASE), .AWIDTH(AW)) dut1 (
    .clock(clock), .reset(reset), .start(start), .bus(bus1),
    .busy(busy1), .frame_done(done1), .checksum(sum1), .frame_count(cnt1));

  frame_sink #(.DWIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .BORDER(0),
               .BASE_ADDR(BASE), .AWIDTH(AW)) dut0 (
    .clock(clock), .reset(reset), .start(start), .bus(bus0),
    .busy(busy0), .frame_done(done0), .checksum(sum0), .frame_count(cnt0));

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic [DW-1:0] pix [NPX];
  logic [DW-1:0] fifo_q [$];
  wr_t           wq1 [$];
  wr_t           wq0 [$];
  int            n = 0;
  bit            active = 1'b0;
  bit            edone = 1'b0;
  logic [31:0]   esum1 = '0;
  logic [31:0]   esum0 = '0;
  int            ecount = 0;
  int            total = 0;
  int            bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_px(input int idx, input int border);
    int x, y;
    x = idx % W;
    y = idx / W;
    if (x < border || x >= W - border || y < border || y >= H - border) return '0;
    return pix[idx];
  endfunction

  task automatic load(input bit rnd);
    fifo_q.delete();
    for (int i = 0; i < NPX; i++) begin
      pix[i] = rnd ? DW'($urandom) : DW'(i + 1);
      fifo_q.push_back(pix[i]);
    end
  endtask

  task automatic observe();
    bit pend;
    pend = (wq1.size() != 0);
    check("wr_en1", bus1.mem_wr_en, pend);
    check("wr_en0", bus0.mem_wr_en, wq0.size() != 0);
    if (pend) begin
      check("addr1", bus1.mem_addr, wq1[0].a);
      check("din1", bus1.mem_din, wq1[0].d);
    end
    if (wq0.size() != 0) begin
      check("addr0", bus0.mem_addr, wq0[0].a);
      check("din0", bus0.mem_din, wq0[0].d);
    end
    check("busy1", busy1, active);
    check("busy0", busy0, active);
    check("done1", done1, edone);
    check("done0", done0, edone);
    if (edone) begin
      check("sum1", sum1, esum1);
      check("sum0", sum0, esum0);
      check("count1", cnt1, ecount);
      check("count0", cnt0, ecount);
    end
  endtask

  // One clock: observe registered outputs, drive inputs, then advance the model.
  task automatic step(input bit st, input bit emp, input bit bsy, input bit rst_in);
    bit exp_rd, acc;
    wr_t w;
    @(negedge clock);
    observe();
    reset      = rst_in;
    start      = st;
    mem_busy   = bsy;
    fifo_empty = emp || (fifo_q.size() == 0);
    fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    #1;
    exp_rd = active && (n < NPX) && !fifo_empty && !((wq1.size() != 0) && bsy);
    check("rd_en1", bus1.fifo_rd_en, exp_rd);
    check("rd_en0", bus0.fifo_rd_en, exp_rd);
    if (bus1.fifo_rd_en && fifo_q.size() != 0) void'(fifo_q.pop_front());
    edone = 1'b0;
    if (rst_in) begin
      active = 1'b0;
      n      = 0;
      wq1.delete();
      wq0.delete();
      esum1  = '0;
      esum0  = '0;
      ecount = 0;
    end else begin
      acc = (wq1.size() != 0) && !bsy;
      if (acc) begin
        esum1 += 32'(wq1[0].d);
        void'(wq1.pop_front());
      end
      if ((wq0.size() != 0) && !bsy) begin
        esum0 += 32'(wq0[0].d);
        void'(wq0.pop_front());
      end
      if (acc && wq1.size() == 0 && active && n == NPX) begin
        active = 1'b0;
        ecount++;
        edone  = 1'b1;
      end
      if (exp_rd) begin
        w.a = AW'(BASE + n);
        w.d = exp_px(n, 1);
        wq1.push_back(w);
        w.d = exp_px(n, 0);
        wq0.push_back(w);
        n++;
      end
      if (st && !active) begin
        active = 1'b1;
        n      = 0;
        esum1  = '0;
        esum0  = '0;
      end
    end
  endtask

  // mode 0 clean, 1 empty every other cycle, 2 stall 5th write, 3 random, 4 extra starts
  task automatic run_frame(input int mode);
    int cyc, acc_cnt, stall, first_acc, last_acc, base_count;
    bit st, emp, bsy, pend;
    cyc = 0; acc_cnt = 0; stall = 0; first_acc = -1; last_acc = -1;
    base_count = ecount;
    while (ecount == base_count && cyc < 300) begin
      pend = (wq1.size() != 0);
      st   = (cyc == 0) || (mode == 4 && cyc % 3 == 2);
      emp  = 1'b0;
      bsy  = 1'b0;
      case (mode)
        1: emp = (cyc % 2 == 1);
        2: if (pend && acc_cnt == 4 && stall < 3) begin bsy = 1'b1; stall++; end
        3: begin
          emp = ($urandom_range(0, 2) == 0);
          bsy = ($urandom_range(0, 2) == 0);
        end
        default: ;
      endcase
      if (pend && !bsy) begin
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        acc_cnt++;
      end
      step(st, emp, bsy, 1'b0);
      cyc++;
    end
    check("frame_timeout", ecount != base_count, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("writes", acc_cnt, NPX);
    if (mode == 0) check("span", last_acc - first_acc, NPX - 1);
    if (mode == 2) check("stall_len", stall, 3);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"}, bus1.mem_addr, 0);
    check({tag, "_din"}, bus1.mem_din, 0);
    check({tag, "_sum"}, sum1, 0);
    check({tag, "_count"}, cnt1, 0);
    check({tag, "_busy"}, busy1, 0);
    check({tag, "_done"}, done1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check_zero("reset");

    load(1'b0);
    run_frame(0);
    check("t1_sum", sum1, 13);
    check("t2_sum", sum0, 78);
    check("t1_count", cnt1, 1);

    load(1'b0);
    run_frame(0);
    check("t2_sum_again", sum0, 78);
    check("t2_count", cnt0, 2);

    load(1'b0);
    run_frame(1);
    check("t3_sum", sum0, 78);

    load(1'b1);
    run_frame(2);

    load(1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30 && n < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t5_pops", n, 6);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check_zero("t5");
    load(1'b1);
    run_frame(0);
    check("t5_count", cnt1, 1);

    load(1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t6_no_pop", fifo_q.size(), NPX);
    run_frame(4);

    for (int f = 0; f < 5; f++) begin
      load(1'b1);
      run_frame(3);
    end
    check("final_count", cnt0, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
